alu_mux_capture: RTL and testbench
==================================

// Module: alu_mux_capture
// PURPOSE
//  Downstream capture stage for the 16-bit 3:1 ALU result mux in the MIPS25 adiabatic datapath.
//  Accepts a source-select request and drives the mux select pair (sel_in1, sel_in0).
//  Waits out the fixed adiabatic propagation latency, samples the mux output, and computes a zero flag.
//  Buffers results in a small FIFO with a valid/ready handshake toward writeback.
// PARAMETERS
//  WIDTH  16  data width of mux output and result
//  LAT    4   cycles from select change to stable mux output (one 4-phase adiabatic period); >=1
//  DEPTH  2   result FIFO entries; power of two, >=2
// PORTS
//  clkpos     in   1      single clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  req_valid  in   1      request to select a source and capture it
//  req_ready  out  1      request accepted when req_valid & req_ready on a clkpos edge
//  req_src    in   2      00=zero(vss) 01=b 10=c 11=d
//  sel_in1    out  1      mux select MSB (in1)
//  sel_in0    out  1      mux select LSB (in0)
//  mux_out    in   WIDTH  16-bit mux output being captured
//  res_valid  out  1      FIFO head valid
//  res_ready  in   1      consumer pops head when res_valid & res_ready
//  res_data   out  WIDTH  FIFO head data
//  res_zero   out  1      FIFO head data == 0
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  - Reset (rst=1 at an edge), all outputs next cycle:
//    FSM=IDLE, sel_in1/sel_in0=00, FIFO empty, res_valid=0, res_data=0, res_zero=0, busy=0, req_ready=1.
//  - FSM states IDLE -> SETTLE -> CAPTURE -> IDLE.
//  - IDLE: req_ready = (fifo_count < DEPTH).
//    On accept, register {sel_in1, sel_in0} = req_src, load cnt = LAT-1, and go to SETTLE.
//  - SETTLE: req_ready=0 and sel held stable.
//    cnt decrements each cycle; at cnt==0 go to CAPTURE.
//  - CAPTURE: push {mux_out, mux_out==0} into FIFO, then go to IDLE. sel stays at last value (no glitch to 00).
//  - Accept-to-push latency is LAT+1 edges. Back-to-back request throughput is one per LAT+2 cycles.
//  - The space reservation is made at accept, so a push never sees a full FIFO.
//    Overflow is impossible by construction; assert this.
//  - Simultaneous push and pop when full or non-empty: both happen and count is unchanged.
//    Simultaneous push and pop when empty: the push only becomes visible next cycle (no bypass).
//  - Pop with res_valid=0 is ignored. Pointers wrap modulo DEPTH.
//  - res_data/res_zero hold the head value and are stable while res_valid & !res_ready.
//  - rst mid-operation (SETTLE/CAPTURE) aborts: no push, FIFO flushed, sel returns to 00.
//  - req_src is sampled only on accept; changes at other times are ignored.
// STRUCTURE
//  - Shared package mips25_alu_pkg holds:
//    typedef enum logic[1:0] {SRC_ZERO, SRC_B, SRC_C, SRC_D} mux_src_t;
//    typedef enum logic[1:0] {S_IDLE, S_SETTLE, S_CAPTURE} cap_state_t;
//    localparam ADIA_PHASES = 4.
//  - One sub-module, res_fifo (WIDTH+1 bits x DEPTH), with push/pop/count/head ports.
//  - FSM and counter are in the top level.
// TESTING
//  - Reset: hold rst 2 cycles with req_valid=1
//    -> sel=00, res_valid=0, busy=0, req_ready=1; no accept during reset.
//  - Single capture: req_src=10, mux_out=16'hA5A5 stable
//    -> sel=10 from the next cycle, res_valid rises LAT+1 edges after accept,
//       res_data=16'hA5A5, res_zero=0.
//  - Zero source: req_src=00, mux_out=16'h0000 -> res_data=0, res_zero=1.
//  - Backpressure: res_ready=0 and 3 requests (b=1,c=2,d=3)
//    -> first two captured in order, req_ready=0 after second accept;
//       releasing res_ready pops 1 then 2, and the third request is accepted only after space frees.
//  - Settle window: mux_out changes during SETTLE and is final 16'h7FFF in the CAPTURE cycle
//    -> only 16'h7FFF captured.
//  - Reset mid-SETTLE with one entry already in FIFO -> FIFO empty, res_valid=0, no stale push afterward.

Source files
------------

// File: rtl/mips25_alu_pkg.sv
// Shared types for the MIPS25 ALU result mux capture stage.
package mips25_alu_pkg;
   typedef enum logic [1:0] {SRC_ZERO, SRC_B, SRC_C, SRC_D} mux_src_t;
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} cap_state_t;
   localparam int ADIA_PHASES = 4;
endpackage

// File: rtl/alu_mux_capture_res_fifo.sv
// Result FIFO: DEPTH entries of W bits, registered head storage, no push-to-head bypass.
module res_fifo
   import mips25_alu_pkg::*;
#(
   parameter int W     = 17,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          pop_ok;

   // A pop against an empty FIFO is dropped rather than moving the read pointer.
   assign pop_ok = pop && (cnt_q != '0);
   assign head   = mem_q[rd_q];
   assign count  = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         assert (!(push && (cnt_q == FULL)))
            else $error("res_fifo overflow: push while full");
         if (push) wr_q <= wr_q + AW'(1);
         if (pop_ok) rd_q <= rd_q + AW'(1);
         case ({push, pop_ok})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_data;
   end

endmodule

// File: rtl/alu_mux_capture.sv
// Capture stage for the 16-bit 3:1 adiabatic ALU result mux: drives the select,
// waits out the settle latency, samples the mux and queues {data, zero} for writeback.
module alu_mux_capture
   import mips25_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LAT   = ADIA_PHASES,
   parameter int DEPTH = 2
) (
   input  logic             clkpos,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_src,
   output logic             sel_in1,
   output logic             sel_in0,
   input  logic [WIDTH-1:0] mux_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             busy
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   cap_state_t      state_q;
   logic [CW-1:0]   cnt_q;
   mux_src_t        sel_q;
   logic            accept;
   logic            push;
   logic [WIDTH:0]  head;
   logic [AW:0]     fifo_count;

   // Space is reserved at accept: only one capture is ever in flight, so a
   // FIFO slot free at accept is still free when CAPTURE pushes.
   assign req_ready = (state_q == S_IDLE) && (fifo_count < FULL);
   assign accept    = req_valid && req_ready;
   assign push      = (state_q == S_CAPTURE);

   always_ff @(posedge clkpos) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= SRC_ZERO;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  sel_q   <= mux_src_t'(req_src);
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) state_q <= S_CAPTURE;
               else             cnt_q   <= cnt_q - CW'(1);
            end
            S_CAPTURE: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   res_fifo #(
      .W     (WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk       (clkpos),
      .rst       (rst),
      .push      (push),
      .push_data ({mux_out, (mux_out == '0)}),
      .pop       (res_ready),
      .head      (head),
      .count     (fifo_count)
   );

   // Head storage is not reset, so the outputs are masked to zero when empty.
   assign res_valid = (fifo_count != '0);
   assign res_data  = res_valid ? head[WIDTH:1] : '0;
   assign res_zero  = res_valid & head[0];
   assign sel_in1   = sel_q[1];
   assign sel_in0   = sel_q[0];
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_mux_capture.sv
// Directed bench for alu_mux_capture (WIDTH=16, LAT=4, DEPTH=2).
module tb_alu_mux_capture;

   localparam int LAT = 4;

   logic        clkpos;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_src;
   logic        sel_in1;
   logic        sel_in0;
   logic [15:0] mux_out;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_zero;
   logic        busy;

   int errors = 0;
   int checks = 0;

   alu_mux_capture #(.WIDTH(16), .LAT(LAT), .DEPTH(2)) dut (
      .clkpos    (clkpos),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .sel_in1   (sel_in1),
      .sel_in0   (sel_in0),
      .mux_out   (mux_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_zero  (res_zero),
      .busy      (busy)
   );

   initial begin
      clkpos = 1'b0;
      forever #5 clkpos = ~clkpos;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clkpos);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // Issue one request and run until its push has landed (accept + LAT+1 edges).
   task automatic do_req(input logic [1:0] src, input logic [15:0] data);
      req_valid = 1'b1;
      req_src   = src;
      mux_out   = data;
      tick();
      req_valid = 1'b0;
      repeat (LAT + 1) tick();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b1;
      req_src   = 2'b11;
      mux_out   = 16'h1234;
      res_ready = 1'b0;
      tick();
      tick();
      chk("rst_sel",       {sel_in1, sel_in0}, 2'b00);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_busy",      busy, 1'b0);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_res_data",  res_data, 16'h0000);
      chk("rst_res_zero",  res_zero, 1'b0);
      req_valid = 1'b0;
      rst       = 1'b0;
      tick();
      chk("post_rst_busy", busy, 1'b0);

      // Single capture of source c
      req_valid = 1'b1;
      req_src   = 2'b10;
      mux_out   = 16'hA5A5;
      tick();
      chk("cap_sel",       {sel_in1, sel_in0}, 2'b10);
      chk("cap_busy",      busy, 1'b1);
      chk("cap_req_ready", req_ready, 1'b0);
      req_valid = 1'b0;
      req_src   = 2'b11;
      repeat (LAT) tick();
      chk("cap_not_early", res_valid, 1'b0);
      chk("cap_sel_held",  {sel_in1, sel_in0}, 2'b10);
      tick();
      chk("cap_valid",     res_valid, 1'b1);
      chk("cap_data",      res_data, 16'hA5A5);
      chk("cap_zero",      res_zero, 1'b0);
      chk("cap_idle",      busy, 1'b0);
      chk("cap_sel_kept",  {sel_in1, sel_in0}, 2'b10);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("cap_popped",    res_valid, 1'b0);

      // Zero source
      do_req(2'b00, 16'h0000);
      chk("zero_sel",   {sel_in1, sel_in0}, 2'b00);
      chk("zero_valid", res_valid, 1'b1);
      chk("zero_data",  res_data, 16'h0000);
      chk("zero_flag",  res_zero, 1'b1);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("zero_popped", res_valid, 1'b0);

      // Backpressure with three requests
      do_req(2'b01, 16'h0001);
      chk("bp_first_data", res_data, 16'h0001);
      do_req(2'b10, 16'h0002);
      chk("bp_full_ready", req_ready, 1'b0);
      chk("bp_head_held",  res_data, 16'h0001);
      req_valid = 1'b1;
      req_src   = 2'b11;
      mux_out   = 16'h0003;
      repeat (3) tick();
      chk("bp_no_accept",  busy, 1'b0);
      chk("bp_still_head", res_data, 16'h0001);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("bp_pop1_data",  res_data, 16'h0002);
      chk("bp_space_ready", req_ready, 1'b1);
      tick();
      chk("bp_third_accept", busy, 1'b1);
      chk("bp_third_sel",  {sel_in1, sel_in0}, 2'b11);
      req_valid = 1'b0;
      repeat (LAT + 1) tick();
      chk("bp_head2_held", res_data, 16'h0002);
      res_ready = 1'b1;
      tick();
      chk("bp_pop2_data",  res_data, 16'h0003);
      tick();
      res_ready = 1'b0;
      chk("bp_drained",    res_valid, 1'b0);

      // mux_out wanders during SETTLE; only the CAPTURE-cycle value is taken
      req_valid = 1'b1;
      req_src   = 2'b01;
      mux_out   = 16'h1111;
      tick();
      req_valid = 1'b0;
      mux_out   = 16'h2222;
      tick();
      mux_out   = 16'h3333;
      tick();
      mux_out   = 16'h0000;
      tick();
      mux_out   = 16'h7FFF;
      tick();
      chk("settle_busy",  busy, 1'b1);
      chk("settle_empty", res_valid, 1'b0);
      tick();
      chk("settle_data",  res_data, 16'h7FFF);
      chk("settle_zero",  res_zero, 1'b0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;

      // Push and pop on the same edge with one entry already held
      do_req(2'b01, 16'h0AAA);
      req_valid = 1'b1;
      req_src   = 2'b10;
      mux_out   = 16'h0BBB;
      tick();
      req_valid = 1'b0;
      repeat (LAT) tick();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("pp_valid", res_valid, 1'b1);
      chk("pp_data",  res_data, 16'h0BBB);
      tick();
      chk("pp_count_kept", res_valid, 1'b1);

      // Push and pop on the same edge into an empty FIFO: pop is ignored
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("pe_empty", res_valid, 1'b0);
      req_valid = 1'b1;
      req_src   = 2'b11;
      mux_out   = 16'h0CCC;
      tick();
      req_valid = 1'b0;
      repeat (LAT) tick();
      res_ready = 1'b1;
      tick();
      chk("pe_no_bypass", res_valid, 1'b1);
      chk("pe_data",      res_data, 16'h0CCC);
      tick();
      res_ready = 1'b0;
      chk("pe_popped", res_valid, 1'b0);

      // Reset mid-SETTLE with one entry queued
      do_req(2'b11, 16'h1234);
      chk("mr_pre_valid", res_valid, 1'b1);
      req_valid = 1'b1;
      req_src   = 2'b10;
      mux_out   = 16'h5555;
      tick();
      req_valid = 1'b0;
      tick();
      chk("mr_in_settle", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_valid", res_valid, 1'b0);
      chk("mr_busy",  busy, 1'b0);
      chk("mr_sel",   {sel_in1, sel_in0}, 2'b00);
      chk("mr_data",  res_data, 16'h0000);
      repeat (LAT + 2) tick();
      chk("mr_no_stale_push", res_valid, 1'b0);
      chk("mr_ready", req_ready, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
